fcs32_check_n: RTL

// - Streaming Ethernet FCS checker, BYTES bytes per beat, generalising the 8-bit checker.
// - Computes CRC-32 over each frame's payload.
//   - Payload is every byte except the trailing 4.
// - Compares the CRC with the trailing 4 FCS bytes and reports one pass/fail result per frame.
// - Sits on the receive datapath after the framer and ahead of the frame filter.
// - No backpressure; accepts a beat every cycle val_i is high.

---
 rtl/fcs32_check_n.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fcs32_check_n.sv
// Streaming Ethernet FCS checker, BYTES bytes per beat; a 4-byte holdback keeps the trailing FCS out of the CRC.
// Optional frame/bad-frame counters are compiled in with `define FCS32_STATS_EN.
module fcs32_check_n #(
   parameter int BYTES = 4,
   parameter int PIPE  = 0,
   parameter int MW    = (BYTES > 1) ? $clog2(BYTES) : 1
) (
   input  logic               pclk_i,
   input  logic               rst_i,
   input  logic [8*BYTES-1:0] dat_i,
   input  logic               val_i,
   input  logic               sof_i,
   input  logic               eof_i,
   input  logic [MW-1:0]      mod_i,
   output logic [31:0]        res_o,
   output logic [31:0]        exp_o,
   output logic [31:0]        obs_o,
   output logic               done_o,
   output logic               ok_o,
   output logic               err_o
`ifdef FCS32_STATS_EN
   ,
   input  logic               clr_i,
   output logic [15:0]        frm_cnt_o,
   output logic [15:0]        bad_cnt_o
`endif
);

   localparam int SW = 32 + 8*BYTES;
   localparam int OW = 3 + 32 + 32;

   typedef enum logic {IDLE, FRAME} state_t;

   function automatic logic [31:0] fcs32_8(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Complemented CRC, byte-swapped so the first FCS byte on the wire lands in [31:24].
   function automatic logic [31:0] fcs32_brev(input logic [31:0] c);
      logic [31:0] f;
      f = ~c;
      return {f[7:0], f[15:8], f[23:16], f[31:24]};
   endfunction

   function automatic logic [15:0] sat16_add(input logic [15:0] a, input logic [3:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {13'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   state_t      state;
   logic [31:0] crc_q;
   logic [31:0] hb_q;
   logic [2:0]  hb_cnt_q;
   logic [15:0] len_q;

   int          nb_p0;
   int          hbc_p0;
   logic [SW-1:0] stream_p0;
   logic [31:0] crc_p0;
   logic [31:0] tail_p0;
   logic [2:0]  hb_nxt_p0;
   logic [15:0] len_p0;
   logic        runt_p0;
   logic        take_p0;

   logic        vld_p1;
   logic        err_p1;
   logic [31:0] obs_p1;

   logic        done_p2;
   logic        ok_p2;
   logic        err_p2;
   logic [31:0] exp_p2;
   logic [31:0] obs_p2;
   logic [OW-1:0] pk_p2;
   logic [OW-1:0] pk_out;

   // ---- stage 0: holdback + beat form one byte stream; all but its last 4 valid bytes enter the CRC
   always_comb begin
      nb_p0 = BYTES;
      if (eof_i && (mod_i != '0))
         nb_p0 = int'(mod_i);
      hbc_p0    = sof_i ? 0 : int'(hb_cnt_q);
      stream_p0 = {hb_q, dat_i};
      crc_p0    = sof_i ? 32'hFFFFFFFF : crc_q;
      for (int i = 0; i < BYTES; i++)
         if ((i + hbc_p0 >= 4) && (i < nb_p0))
            crc_p0 = fcs32_8(crc_p0, stream_p0[SW-1-8*i -: 8]);
      tail_p0   = 32'(stream_p0 >> (8*(BYTES - nb_p0)));
      hb_nxt_p0 = (hbc_p0 + nb_p0 > 4) ? 3'd4 : 3'(hbc_p0 + nb_p0);
      len_p0    = sat16_add(sof_i ? 16'd0 : len_q, 4'(nb_p0));
      runt_p0   = (len_p0 < 16'd5);
      take_p0   = val_i && (sof_i || (state == FRAME));
   end

   // ---- stage 1: frame state, running CRC, holdback
   always_ff @(posedge pclk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         crc_q    <= 32'hFFFFFFFF;
         hb_cnt_q <= 3'd0;
         len_q    <= 16'd0;
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         err_p1 <= 1'b0;
         if (take_p0) begin
            crc_q    <= crc_p0;
            hb_cnt_q <= hb_nxt_p0;
            len_q    <= len_p0;
            // sof inside a frame aborts it; if the new beat is also eof the single pulse carries err
            if (eof_i) begin
               vld_p1 <= 1'b1;
               err_p1 <= (sof_i && (state == FRAME)) || runt_p0;
               state  <= IDLE;
            end else begin
               vld_p1 <= sof_i && (state == FRAME);
               err_p1 <= sof_i && (state == FRAME);
               state  <= FRAME;
            end
         end else if (val_i && eof_i) begin
            vld_p1 <= 1'b1;
            err_p1 <= 1'b1;
         end
      end
   end

   // After an eof beat the holdback holds exactly the received FCS, so it doubles as exp.
   always_ff @(posedge pclk_i) begin
      if (take_p0)
         hb_q <= tail_p0;
   end

   assign obs_p1 = fcs32_brev(crc_q);
   assign res_o  = crc_q;

   // ---- stage 2: compare and register results
   always_ff @(posedge pclk_i or posedge rst_i) begin
      if (rst_i) begin
         done_p2 <= 1'b0;
         ok_p2   <= 1'b0;
         err_p2  <= 1'b0;
         exp_p2  <= 32'd0;
         obs_p2  <= 32'd0;
      end else begin
         done_p2 <= vld_p1;
         if (vld_p1) begin
            exp_p2 <= hb_q;
            obs_p2 <= obs_p1;
            ok_p2  <= !err_p1 && (hb_q == obs_p1);
            err_p2 <= err_p1;
         end
      end
   end

   assign pk_p2 = {done_p2, ok_p2, err_p2, exp_p2, obs_p2};

   // ---- optional alignment stages
   generate
      if (PIPE == 0) begin : g_nopipe
         assign pk_out = pk_p2;
      end else begin : g_pipe
         logic [OW-1:0] pq [PIPE];
         always_ff @(posedge pclk_i or posedge rst_i) begin
            if (rst_i) begin
               for (int s = 0; s < PIPE; s++)
                  pq[s] <= '0;
            end else begin
               pq[0] <= pk_p2;
               for (int s = 1; s < PIPE; s++)
                  pq[s] <= pq[s-1];
            end
         end
         assign pk_out = pq[PIPE-1];
      end
   endgenerate

   assign {done_o, ok_o, err_o, exp_o, obs_o} = pk_out;

`ifdef FCS32_STATS_EN
   always_ff @(posedge pclk_i or posedge rst_i) begin
      if (rst_i) begin
         frm_cnt_o <= 16'd0;
         bad_cnt_o <= 16'd0;
      end else if (clr_i) begin
         frm_cnt_o <= 16'd0;
         bad_cnt_o <= 16'd0;
      end else if (done_o) begin
         frm_cnt_o <= sat16_add(frm_cnt_o, 4'd1);
         if (!ok_o)
            bad_cnt_o <= sat16_add(bad_cnt_o, 4'd1);
      end
   end
`endif

endmodule
